bcd_digit_accum: RTL and testbench

- Sequential stage directly downstream of the Excess-3 to BCD converter.
- Accepts one 4-bit BCD digit per handshake, most-significant digit first.
- After NDIG digits, presents two results together:
  - the packed BCD word;
  - its binary equivalent, built by multiply-by-10 accumulation.
- Flags any non-decimal digit (value > 9) received within the word.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_mac10.sv | 30 +++
 rtl/bcd_digit_accum.sv | 99 +++++++++
 tb/tb_bcd_digit_accum.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit accumulation stages: FSM encoding,
// the largest legal decimal digit and a helper for sizing binary results.
package bcd_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Smallest width w with 2^w > 10^ndig - 1, i.e. enough to hold ndig nines.
  function automatic int min_bw(input int ndig);
    longint lim;
    int     w;
    bit     found;
    lim   = 1;
    w     = 0;
    found = 1'b0;
    for (int i = 0; i < ndig; i++) lim = lim * 10;
    lim = lim - 1;
    for (int i = 0; i < 63; i++) begin
      if (!found && ((longint'(1) << i) > lim)) begin
        w     = i;
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-10-and-add step for decimal to binary conversion.
// Non-decimal digits contribute zero and are reported through digit_bad.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int BW = 14
) (
  input  logic [BW-1:0] acc,
  input  logic [3:0]    din,
  output logic [BW-1:0] next_acc,
  output logic          digit_bad
);

  logic [BW+3:0] wide_acc;
  logic [BW+3:0] sum;
  logic [3:0]    digit;
  logic          unused_hi;

  assign digit_bad = (din > BCD_MAX);
  assign digit     = digit_bad ? 4'd0 : din;
  assign wide_acc  = {4'b0000, acc};

  // x*10 as x*8 + x*2 keeps the step to shifts and adders.
  assign sum       = (wide_acc << 3) + (wide_acc << 1) + (BW + 4)'(digit);
  assign next_acc  = sum[BW-1:0];

  // Headroom bits are dropped on purpose: the result wraps to BW bits.
  assign unused_hi = ^sum[BW+3:BW];

endmodule

// File: rtl/bcd_digit_accum.sv
// Collects NDIG BCD digits (MS digit first) into a packed BCD word and its
// binary value, then holds the result until the downstream handshake.
module bcd_digit_accum
  import bcd_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int BW   = min_bw(NDIG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [3:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [4*NDIG-1:0] bcd_word,
  output logic [BW-1:0]     bin,
  output logic              err,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int             CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(NDIG - 1);

  state_e            state;
  state_e            state_next;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     acc_next;
  logic [4*NDIG-1:0] shreg;
  logic [4*NDIG-1:0] shreg_next;
  logic              digit_bad;
  logic              accept;
  logic              last_digit;
  logic              release_word;

  bcd_mac10 #(.BW(BW)) u_mac10 (
    .acc       (acc),
    .din       (din),
    .next_acc  (acc_next),
    .digit_bad (digit_bad)
  );

  if (NDIG == 1) begin : g_single
    assign shreg_next = din;
  end else begin : g_multi
    assign shreg_next = {shreg[4*NDIG-5:0], din};
  end

  assign din_ready    = (state == COLLECT) && !clr;
  assign accept       = din_valid && din_ready;
  assign last_digit   = (cnt == CNT_LAST);
  assign release_word = (state == HOLD) && out_ready;

  assign out_valid    = (state == HOLD);
  assign bcd_word     = shreg;
  assign bin          = acc;

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (clr) begin
      state_next = COLLECT;
    end else if (accept && last_digit) begin
      state_next = HOLD;
    end else if (release_word) begin
      state_next = COLLECT;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      shreg <= '0;
      err   <= 1'b0;
    end else if (clr || release_word) begin
      cnt   <= '0;
      acc   <= '0;
      shreg <= '0;
      err   <= 1'b0;
    end else if (accept) begin
      acc   <= acc_next;
      shreg <= shreg_next;
      err   <= err | digit_bad;
      cnt   <= last_digit ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_bcd_digit_accum.sv
// Scoreboard bench for bcd_digit_accum: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them on every output handshake.
module tb_bcd_digit_accum;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [3:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] bcd_word;
  logic [13:0] bin;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   hs_count = 0;

  bcd_digit_accum #(.NDIG(4), .BW(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .bcd_word  (bcd_word),
    .bin       (bin),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      hs_count++;
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check("res_bcd_word", 32'(bcd_word), 32'(e.bcd));
        check("res_bin",      32'(bin),      32'(e.bin));
        check("res_err",      32'(err),      32'(e.err));
      end
    end
  end

  // Presents one digit and returns #1 after the edge that accepted it.
  task automatic send_digit(input logic [3:0] d);
    int n;
    n = 0;
    din       = d;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) check("din_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] digits, input logic [15:0] exp_bcd,
                           input logic [13:0] exp_bin, input logic exp_err, input bit gaps);
    exp_t e;
    e.bcd = exp_bcd;
    e.bin = exp_bin;
    e.err = exp_err;
    sb.push_back(e);
    for (int i = 3; i >= 0; i--) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      send_digit(digits[4*i +: 4]);
    end
  endtask

  initial begin
    int h0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    din       = 4'd0;
    din_valid = 1'b0;
    out_ready = 1'b1;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_bcd_word",  32'(bcd_word),  32'd0);
    check("rst_bin",       32'(bin),       32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic word, continuous valid.
    send_word(16'h1234, 16'h1234, 14'd1234, 1'b0, 1'b0);
    check("basic_latency_out_valid", 32'(out_valid), 32'd1);
    check("basic_hold_din_ready",    32'(din_ready), 32'd0);
    @(posedge clk);
    #1;
    check("basic_after_out_valid", 32'(out_valid), 32'd0);
    check("basic_after_bin",       32'(bin),       32'd0);
    check("basic_after_din_ready", 32'(din_ready), 32'd1);

    // Max then min, back to back.
    send_word(16'h9999, 16'h9999, 14'd9999, 1'b0, 1'b0);
    check("max_hold_din_ready", 32'(din_ready), 32'd0);
    check("max_bin_hex",        32'(bin),       32'h270F);
    send_word(16'h0000, 16'h0000, 14'd0, 1'b0, 1'b0);

    // Gapped input, then backpressure.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_word(16'h5072, 16'h5072, 14'd5072, 1'b0, 1'b1);
    repeat (6) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_bcd_word",  32'(bcd_word),  32'h5072);
      check("bp_bin",       32'(bin),       32'd5072);
      check("bp_din_ready", 32'(din_ready), 32'd0);
    end
    h0 = hs_count;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("bp_single_handshake", 32'(hs_count), 32'(h0 + 1));

    // Non-decimal digit, then a clean word.
    send_word(16'h9C05, 16'h9C05, 14'd9005, 1'b1, 1'b0);
    send_word(16'h1111, 16'h1111, 14'd1111, 1'b0, 1'b0);

    // clr mid-word drops the partial word and the digit presented with it.
    @(posedge clk);
    #1;
    send_digit(4'd3);
    send_digit(4'd8);
    din       = 4'd6;
    din_valid = 1'b1;
    clr       = 1'b1;
    @(negedge clk);
    check("clr_din_ready", 32'(din_ready), 32'd0);
    @(posedge clk);
    #1;
    clr       = 1'b0;
    din_valid = 1'b0;
    check("clr_bin",      32'(bin),      32'd0);
    check("clr_bcd_word", 32'(bcd_word), 32'd0);
    send_word(16'h2468, 16'h2468, 14'd2468, 1'b0, 1'b0);

    // Reset mid-word acts asynchronously.
    @(posedge clk);
    #1;
    send_digit(4'd1);
    send_digit(4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bin",       32'(bin),       32'd0);
    check("arst_bcd_word",  32'(bcd_word),  32'd0);
    check("arst_din_ready", 32'(din_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset while holding a result clears out_valid at once.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_digit(4'd3);
    check("hold_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hold_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    send_word(16'h0042, 16'h0042, 14'd42, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
